// File: rtl/instruction_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instruction_prefetch_queue
//
// Byte-granular circular prefetch queue sitting between the bus/fetch unit and
// decode_stage_prefix. The fetch side pushes up to FETCH_BYTES code bytes per
// beat; decode sees a WINDOW-byte look-ahead starting at the queue head and
// retires 1..WINDOW bytes per cycle once it has sized an instruction. A flush
// (branch or exception) drops everything queued.
//
// Ports
//   i_clock             rising-edge clock
//   i_reset_n           asynchronous active-low reset
//   i_flush             discard all queued bytes (highest priority)
//   i_fetch_valid       fetch beat present
//   i_fetch_data        fetch bytes, lane 0 = [7:0] = lowest address
//   i_fetch_byte_count  valid low lanes in the beat, 1..FETCH_BYTES
//   o_fetch_ready       free space >= FETCH_BYTES
//   o_instruction       look-ahead window, [0] = head byte, 8'h00 past valid
//   o_valid_bytes       valid window bytes, min(occupancy, WINDOW)
//   i_consume_valid     decode retires bytes this cycle
//   i_consume_bytes     bytes retired, 1..o_valid_bytes
//   o_consume_error     one-cycle pulse: previous consume was illegal
//   o_occupancy         bytes held, 0..DEPTH_BYTES
// -----------------------------------------------------------------------------
module instruction_prefetch_queue #(
    parameter int DEPTH_BYTES = 32,
    parameter int WINDOW      = 16,
    parameter int FETCH_BYTES = 4
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset_n,
    input  logic                                 i_flush,
    input  logic                                 i_fetch_valid,
    input  logic [8*FETCH_BYTES-1:0]             i_fetch_data,
    input  logic [$clog2(FETCH_BYTES+1)-1:0]     i_fetch_byte_count,
    output logic                                 o_fetch_ready,
    output logic [7:0]                           o_instruction [0:WINDOW-1],
    output logic [$clog2(WINDOW+1)-1:0]          o_valid_bytes,
    input  logic                                 i_consume_valid,
    input  logic [$clog2(WINDOW+1)-1:0]          i_consume_bytes,
    output logic                                 o_consume_error,
    output logic [$clog2(DEPTH_BYTES+1)-1:0]     o_occupancy
);

    localparam int PTR_W = $clog2(DEPTH_BYTES);
    localparam int OCC_W = $clog2(DEPTH_BYTES + 1);
    localparam int VB_W  = $clog2(WINDOW + 1);
    localparam int CNT_W = $clog2(FETCH_BYTES + 1);

    // Registered state
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [OCC_W-1:0] r_occupancy;
    logic             r_consume_error;
    logic [7:0]       r_mem [DEPTH_BYTES];

    // Decoded control
    logic             w_fetch_ready;
    logic [VB_W-1:0]  w_valid_bytes;
    logic             w_fetch_count_ok;
    logic             w_fetch_fire;
    logic             w_consume_legal;
    logic             w_consume_fire;
    logic             w_consume_illegal;
    logic [OCC_W-1:0] w_bytes_in;
    logic [OCC_W-1:0] w_bytes_out;

    // Ready only when a full-width beat is guaranteed to fit, so the source
    // never has to know how many lanes the next beat will carry.
    assign w_fetch_ready = (r_occupancy <= OCC_W'(DEPTH_BYTES - FETCH_BYTES));

    assign w_valid_bytes = (r_occupancy >= OCC_W'(WINDOW)) ? VB_W'(WINDOW)
                                                           : VB_W'(r_occupancy);

    // Byte counts of 0 or above FETCH_BYTES are treated as an empty beat.
    assign w_fetch_count_ok = (i_fetch_byte_count != '0) &&
                              (i_fetch_byte_count <= CNT_W'(FETCH_BYTES));

    // Flush squashes both sides of the queue, including the error report.
    assign w_fetch_fire      = !i_flush && i_fetch_valid && w_fetch_ready && w_fetch_count_ok;
    assign w_consume_legal   = (i_consume_bytes != '0) && (i_consume_bytes <= w_valid_bytes);
    assign w_consume_fire    = !i_flush && i_consume_valid && w_consume_legal;
    assign w_consume_illegal = !i_flush && i_consume_valid && !w_consume_legal;

    assign w_bytes_in  = w_fetch_fire   ? OCC_W'(i_fetch_byte_count) : '0;
    assign w_bytes_out = w_consume_fire ? OCC_W'(i_consume_bytes)    : '0;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_occupancy     <= '0;
            r_consume_error <= 1'b0;
        end else begin
            r_consume_error <= w_consume_illegal;
            if (i_flush) begin
                r_head      <= '0;
                r_tail      <= '0;
                r_occupancy <= '0;
            end else begin
                if (w_fetch_fire)
                    r_tail <= r_tail + PTR_W'(i_fetch_byte_count);
                if (w_consume_fire)
                    r_head <= r_head + PTR_W'(i_consume_bytes);
                r_occupancy <= r_occupancy + w_bytes_in - w_bytes_out;
            end
        end
    end

    // NOTE: the byte array has no reset; bytes outside head..tail are never
    // presented (the window masks them to 8'h00), so clearing it buys nothing
    // and would keep it from mapping onto plain RAM.
    // Pointers are power-of-two wide, so tail+i wraps a beat across the end
    // of storage without any extra logic.
    always_ff @(posedge i_clock) begin
        for (int i = 0; i < FETCH_BYTES; i++) begin
            if (w_fetch_fire && (CNT_W'(i) < i_fetch_byte_count))
                r_mem[r_tail + PTR_W'(i)] <= i_fetch_data[8*i +: 8];
        end
    end

    // Window decodes purely from registered state; unused lanes read 8'h00,
    // which decode_stage_prefix treats as a non-prefix byte.
    always_comb begin
        for (int k = 0; k < WINDOW; k++) begin
            o_instruction[k] = (VB_W'(k) < w_valid_bytes) ? r_mem[r_head + PTR_W'(k)]
                                                          : 8'h00;
        end
    end

    assign o_fetch_ready   = w_fetch_ready;
    assign o_valid_bytes   = w_valid_bytes;
    assign o_consume_error = r_consume_error;
    assign o_occupancy     = r_occupancy;

endmodule
